dmem_store_buffer: RTL

- Write-back buffer between the pipelined core's memory stage (address_dmem, data, wren) and data memory.
- Queues stores in a small FIFO and drains them to memory with a ready handshake, so a slow memory write does not stall the M stage.
- Loads go straight to memory; a load whose address matches a buffered store is forwarded the youngest buffered value.

---
 rtl/dmem_store_buffer_pkg.sv | 15 +
 rtl/sb_match.sv | 36 +++
 rtl/dmem_store_buffer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dmem_store_buffer_pkg.sv
// Shared types and sizing for the data-memory store buffer.
package dmem_store_buffer_pkg;

    localparam int DEPTH_DEFAULT  = 4;
    localparam int ADDR_W_DEFAULT = 32;
    localparam int DATA_W_DEFAULT = 32;
    localparam int PTR_W          = $clog2(DEPTH_DEFAULT);
    localparam int CNT_W          = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W_DEFAULT-1:0] addr;
        logic [DATA_W_DEFAULT-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Address compare across buffered stores; the youngest valid match (nearest tail) wins.
module sb_match
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic [ADDR_W-1:0]        addr_arr [DEPTH],
    input  logic [DATA_W-1:0]        data_arr [DEPTH],
    input  logic [DEPTH-1:0]         valid,
    input  logic [$clog2(DEPTH)-1:0] tail,
    input  logic [ADDR_W-1:0]        lookup,
    output logic                     hit,
    output logic [DATA_W-1:0]        hit_data
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk backwards from tail-1 (youngest) to tail-DEPTH (oldest).
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            idx = tail - PW'(k);
            if (!hit && valid[idx] && (addr_arr[idx] == lookup)) begin
                hit      = 1'b1;
                hit_data = data_arr[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Store buffer between the M stage and data memory. Macro STORE_FWD_EN enables
// forwarding of buffered store data to matching loads; otherwise such loads stall.
module dmem_store_buffer
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]        cpu_data,
    input  logic                     cpu_wren,
    input  logic                     cpu_rden,
    output logic [DATA_W-1:0]        cpu_q,
    output logic                     cpu_stall,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_data,
    output logic                     mem_wren,
    input  logic                     mem_ready,
    input  logic [DATA_W-1:0]        mem_q,
    output logic [$clog2(DEPTH):0]   sb_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_arr [DEPTH];
    logic [DATA_W-1:0] data_arr [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;

    logic              full;
    logic              push;
    logic              pop;
    logic              load;
    logic              load_miss;
    logic              drain;
    logic              hit;
    logic [DATA_W-1:0] hit_data;

    sb_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_match (
        .addr_arr (addr_arr),
        .data_arr (data_arr),
        .valid    (valid),
        .tail     (tail),
        .lookup   (cpu_addr),
        .hit      (hit),
        .hit_data (hit_data)
    );

    // A simultaneous store wins; the load half of such a request is dropped.
    assign full      = (count == CW'(DEPTH));
    assign push      = cpu_wren && !full;
    assign load      = cpu_rden && !cpu_wren;
    assign load_miss = load && !hit;
    assign drain     = !load_miss && (count != '0);

    // Memory write handshake: mem_wren is valid, mem_ready is ready; an entry
    // transfers on a cycle where both are 1, and while mem_wren=1 with
    // mem_ready=0 the head entry holds mem_addr/mem_data stable.
    assign pop      = drain && mem_ready;
    assign sb_count = count;

    always_comb begin
        mem_wren  = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        cpu_q     = '0;
        cpu_stall = 1'b0;
        if (reset) begin
            cpu_stall = cpu_wren && full;
            if (load_miss) begin
                mem_addr = cpu_addr;
                cpu_q    = mem_q;
            end else if (drain) begin
                mem_wren = 1'b1;
                mem_addr = addr_arr[head];
                mem_data = data_arr[head];
            end
`ifdef STORE_FWD_EN
            if (load && hit) cpu_q = hit_data;
`else
            if (load && hit) cpu_stall = 1'b1;
`endif
        end
    end

`ifndef STORE_FWD_EN
    logic unused_hit_data;
    assign unused_hit_data = ^hit_data;
`endif

    always_ff @(posedge clock) begin
        if (push) begin
            addr_arr[tail] <= cpu_addr;
            data_arr[tail] <= cpu_data;
        end
    end

    // Push and pop never target the same slot: a pop needs count>0 and a push count<DEPTH.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
